tt_um_conn_check: RTL and testbench

Parametrised, sequential connectivity self-test user module for the multiplexer's user slots. It lets silicon and formal benches prove that `ui_in`, `uo_out`, the `uio` pins, `ena`, `clk` and `rst_n` are wired correctly through the mux. It offers four modes: delayed loopback, inverted loopback, LFSR pattern generator and MISR input signature, plus an enable-cycle counter on the bidirectional pins. When `ena` is low the block holds state and drives every output to 0, so the mux-level "disabled slot outputs zero" property stays checkable.

---
 rtl/tt_um_conn_check.sv | 93 +++++++++
 tb/tb_tt_um_conn_check.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_conn_check.sv
// Connectivity self-test user slot: delayed/inverted loopback, LFSR pattern
// generator, MISR input signature, and an enable-cycle counter on the uio pins.
// With ena low every register holds and every output reads zero.
module tt_um_conn_check #(
  parameter int          PIPE_DEPTH = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'h01,
  parameter int          CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // An all-zero seed would park the LFSR, so it is promoted to 8'h01.
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [1:0]       mode;
  logic             clr;
  logic [7:0]       pipe [PIPE_DEPTH];
  logic [7:0]       lfsr;
  logic [7:0]       sig;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [7:0]       lfsr_next;
  logic [7:0]       sig_next;
  logic [CNT_W-1:0] cnt_plus;
  logic             unused_ok;

  assign mode      = uio_in[1:0];
  assign clr       = uio_in[2];
  assign unused_ok = ^uio_in[7:3];

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign sig_next  = {sig[6:0], sig[7] ^ sig[5] ^ sig[4] ^ sig[3]} ^ ui_in;
  assign cnt_plus  = cnt + CNT_W'(1);

  // Loopback delay line; shifts on every enabled edge regardless of mode and
  // is deliberately untouched by the synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= 8'h00;
    end else if (ena) begin
      pipe[0] <= ui_in;
      for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  // LFSR, MISR and saturating counter; clear beats any mode-driven update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
      sig  <= 8'h00;
      cnt  <= '0;
      sat  <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        lfsr <= SEED;
        sig  <= 8'h00;
        cnt  <= '0;
        sat  <= 1'b0;
      end else begin
        if (mode == 2'd2) lfsr <= (lfsr == 8'h00) ? 8'h01 : lfsr_next;
        if (mode == 2'd3) sig  <= sig_next;
        if (!(&cnt)) cnt <= cnt_plus;
        // sat rises on the edge that lands on all-ones and then sticks.
        if ((&cnt) || (&cnt_plus)) sat <= 1'b1;
      end
    end
  end

  // Output mux, forced to zero whenever the slot is disabled.
  always_comb begin
    uo_out  = 8'h00;
    uio_out = 8'h00;
    uio_oe  = 8'h00;
    if (ena) begin
      unique case (mode)
        2'd0: uo_out = pipe[PIPE_DEPTH-1];
        2'd1: uo_out = ~pipe[PIPE_DEPTH-1];
        2'd2: uo_out = lfsr;
        2'd3: uo_out = sig;
      endcase
      uio_out = {sat, cnt[CNT_W-1 -: 4], 3'b000};
      uio_oe  = 8'hF8;
    end
  end

endmodule

// File: tb/tb_tt_um_conn_check.sv
module tb_tt_um_conn_check;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_conn_check #(.PIPE_DEPTH(2), .LFSR_SEED(8'h01), .CNT_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(0);
  endtask

  initial begin
    logic [7:0] lfsr_seq [6];
    lfsr_seq[0] = 8'h01; lfsr_seq[1] = 8'h02; lfsr_seq[2] = 8'h04;
    lfsr_seq[3] = 8'h08; lfsr_seq[4] = 8'h11; lfsr_seq[5] = 8'h23;

    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #12;
    // reset values, all modes
    chk("rst_m0", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hF8);
    uio_in = 8'h01; #1 chk("rst_m1", uo_out, 8'hFF);
    uio_in = 8'h02; #1 chk("rst_m2", uo_out, 8'h01);
    uio_in = 8'h03; #1 chk("rst_m3", uo_out, 8'h00);
    ena = 1'b0; #1;
    chk("rst_dis_uo", uo_out, 8'h00);
    chk("rst_dis_oe", uio_oe, 8'h00);
    ena = 1'b1; uio_in = 8'h00;
    rst_n = 1'b1;

    // loopback
    do_reset();
    ui_in = 8'h5A; step(1);
    chk("loop_e1", uo_out, 8'h00);
    uio_in = 8'h01; #1 chk("loop_e1_inv", uo_out, 8'hFF);
    uio_in = 8'h00;
    ui_in = 8'h00; step(1);
    chk("loop_e2", uo_out, 8'h5A);
    uio_in = 8'h01; #1 chk("loop_e2_inv", uo_out, 8'hA5);
    uio_in = 8'h00;
    step(1);
    chk("loop_e3", uo_out, 8'h00);
    uio_in = 8'h01; #1 chk("loop_e3_inv", uo_out, 8'hFF);

    // LFSR sequence with an enable gap
    do_reset();
    uio_in = 8'h02; #1;
    chk("lfsr_0", uo_out, lfsr_seq[0]);
    for (int i = 1; i < 6; i++) begin
      step(1);
      chk("lfsr_seq", uo_out, lfsr_seq[i]);
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("lfsr_dis", uo_out, 8'h00);
    end
    ena = 1'b1; #1;
    chk("lfsr_hold", uo_out, 8'h23);
    step(1);
    chk("lfsr_resume", uo_out, 8'h47);

    // async reset mid-run at lfsr=23
    do_reset();
    uio_in = 8'h02;
    step(5);
    chk("arst_pre", uo_out, 8'h23);
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("arst_lfsr", uo_out, 8'h01);
    chk("arst_cnt", uio_out, 8'h00);
    rst_n = 1'b1;

    // MISR
    do_reset();
    uio_in = 8'h07; step(1);
    uio_in = 8'h03; #1;
    chk("misr_clr", uo_out, 8'h00);
    ui_in = 8'h01; step(1);
    chk("misr_1", uo_out, 8'h01);
    ui_in = 8'h00; step(1);
    chk("misr_2", uo_out, 8'h02);

    // counter, CNT_W=6
    do_reset();
    uio_in = 8'h00;
    step(4);
    chk("cnt_4", uio_out, 8'h08);
    step(58);
    chk("cnt_62", uio_out, 8'h78);
    step(1);
    chk("cnt_63", uio_out, 8'hF8);
    step(10);
    chk("cnt_hold", uio_out, 8'hF8);
    uio_in = 8'h04; step(1);
    uio_in = 8'h00; #1;
    chk("cnt_clr", uio_out, 8'h00);
    // clear on the edge that would saturate
    step(62);
    chk("cnt_62b", uio_out, 8'h78);
    uio_in = 8'h04; step(1);
    uio_in = 8'h00; #1;
    chk("cnt_clr_sat", uio_out, 8'h00);

    // disable gating with random inputs
    do_reset();
    uio_in = 8'h02; ui_in = 8'h00;
    step(5);
    chk("gate_pre_uo", uo_out, 8'h23);
    chk("gate_pre_uio", uio_out, 8'h08);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      step(1);
      chk("gate_uo", uo_out, 8'h00);
      chk("gate_uio", uio_out, 8'h00);
      chk("gate_oe", uio_oe, 8'h00);
    end
    ui_in = 8'h00; uio_in = 8'h02; ena = 1'b1; #1;
    chk("gate_post_lfsr", uo_out, 8'h23);
    chk("gate_post_cnt", uio_out, 8'h08);
    uio_in = 8'h00; #1 chk("gate_post_pipe", uo_out, 8'h00);
    uio_in = 8'h03; #1 chk("gate_post_sig", uo_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
